function_accumulator: RTL
=========================

FUNCTION_ACCUMULATOR -- requirements
Module: function_accumulator

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; the clock port is named clk and the reset port is named rst.
REQ-002 Parameter DATA_WIDTH, default 32: operand/result width, signed two's complement fixed point.
REQ-003 Parameter FRAC_BITS, default 16: fractional bits of operands, result and accumulator.
REQ-004 Parameter ACC_WIDTH, default 48: signed accumulator width; legal only if ACC_WIDTH >= 2*DATA_WIDTH-FRAC_BITS.
REQ-005 Parameter CNT_WIDTH, default 16: GO-operation counter width.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 clk_en  input  1  global enable; low freezes every register, FSM included.
REQ-009 start  input  1  operation request, sampled when clk_en=1 in IDLE.
REQ-010 n  input  2  opcode: 0 CLEAR, 1 GO, 2 READ, 3 COUNT.
REQ-011 x_one  input  DATA_WIDTH  lane-0 operand.
REQ-012 x_two  input  DATA_WIDTH  lane-1 operand.
REQ-013 result  output  DATA_WIDTH  registered operation result.
REQ-014 done  output  1  registered one-cycle completion pulse.
REQ-015 overflow  output  1  sticky accumulator-saturation flag.

Function
REQ-016 SHALL implement FSM states IDLE, MULT, ACCUM, DONE; all other encodings return to IDLE.
REQ-017 IDLE: start=1 and clk_en=1 at edge T captures n, x_one, x_two; start is ignored in every other state.
REQ-018 GO: IDLE->MULT; two parallel iterative shift-add multipliers compute x_one*x_one and x_two*x_two in exactly DATA_WIDTH cycles (T+1..T+DATA_WIDTH); then ACCUM at T+DATA_WIDTH+1; then DONE.
REQ-019 Per lane f(x) = (x*x >> FRAC_BITS) + (x >>> 1); product is full 2*DATA_WIDTH bits, both shifts arithmetic (floor).
REQ-020 ACCUM: sum <= sat_ACC(sum + f(x_one) + f(x_two)) computed at ACC_WIDTH+2 bits; on saturation sum clamps to signed ACC_WIDTH max/min and overflow sets.
REQ-021 ACCUM: count increments by 1, holding at all-ones (no wrap).
REQ-022 GO result = new sum saturated to signed DATA_WIDTH (0x7FFF.. / 0x8000..).
REQ-023 CLEAR: sum, count, overflow <= 0; result <= 0; IDLE->DONE.
REQ-024 READ: result <= sum saturated to signed DATA_WIDTH; sum unchanged; IDLE->DONE.
REQ-025 COUNT: result <= count zero-extended (truncated to low DATA_WIDTH bits if CNT_WIDTH > DATA_WIDTH); IDLE->DONE.
REQ-026 DONE: done=1 for exactly one enabled cycle, then IDLE; done=0 in all other states; result holds until next operation's DONE.
REQ-027 Latency from start edge T: done high in cycle T+1 for CLEAR/READ/COUNT, T+DATA_WIDTH+2 for GO.
REQ-028 clk_en=0 in any state: no state, counter, datapath or output change; done stays at its current level; operation resumes when clk_en returns.
REQ-029 Operand changes after T SHALL not affect an in-flight GO.
REQ-030 overflow SHALL only clear on CLEAR or reset.

Reset
REQ-031 rst=1 asynchronously forces state IDLE, sum=0, count=0, result=0, done=0, overflow=0, multiplier registers 0.
REQ-032 rst during MULT/ACCUM aborts the GO: no accumulate, no count increment, no done pulse.
REQ-033 First operation accepted at first enabled edge after rst deasserts.

Verification (DATA_WIDTH=32, FRAC_BITS=16, ACC_WIDTH=48)
REQ-034 Reset, CLEAR, GO x_one=0x00020000 x_two=0xFFFF0000 -> done at T+34, result=0x00058000 (5.0+0.5); READ -> 0x00058000 at T+1; COUNT -> 0x00000001.
REQ-035 GO x_one=x_two=0x7FFFFFFF -> sum clamps to 2^47-1, overflow=1, result=0x7FFFFFFF; CLEAR -> overflow=0, READ=0.
REQ-036 GO with clk_en low for 5 cycles mid-MULT -> done at T+39, same result as uninterrupted; start pulses during busy ignored (COUNT increments once).
REQ-037 Assert rst at T+10 of a GO -> no done, READ after release returns 0, COUNT returns 0.
REQ-038 GO x_one=0xFFFFFFFF (-2^-16), x_two=0 -> f=0 + (-1 LSB) => result=0xFFFFFFFF, confirming floor shift and tiny square truncating to 0.

Source files
------------

// File: rtl/function_accumulator.sv
// function_accumulator: fixed-point squaring accumulator.
// Each GO squares both lane operands with two iterative shift-add
// multipliers and adds f(x) = (x*x >> FRAC_BITS) + (x >>> 1) for each lane
// into a saturating accumulator. CLEAR, READ and COUNT complete in one cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; opcode and operands captured on start
// MULT   | DATA_WIDTH shift-add iterations for both lanes in parallel
// ACCUM  | saturating accumulate, count update, GO result formed
// DONE   | done high for one enabled cycle, then back to IDLE
module function_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            n,
  input  logic [DATA_WIDTH-1:0] x_one,
  input  logic [DATA_WIDTH-1:0] x_two,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  overflow
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 2;
  localparam int IW = $clog2(DATA_WIDTH + 1);

  // Spare encodings exist so that an upset state register falls back to IDLE.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_GO    = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_COUNT = 2'd3;

  logic [2:0]           state_q,       state_d;
  logic [IW-1:0]        iter_q,        iter_d;
  logic [DW-1:0]        xo_q,          xo_d;
  logic [DW-1:0]        xt_q,          xt_d;
  logic [PW-1:0]        mcand_one_q,   mcand_one_d;
  logic [PW-1:0]        mcand_two_q,   mcand_two_d;
  logic [DW-1:0]        mplier_one_q,  mplier_one_d;
  logic [DW-1:0]        mplier_two_q,  mplier_two_d;
  logic [PW-1:0]        prod_one_q,    prod_one_d;
  logic [PW-1:0]        prod_two_q,    prod_two_d;
  logic [ACC_WIDTH-1:0] sum_q,         sum_d;
  logic [CNT_WIDTH-1:0] count_q,       count_d;
  logic [DW-1:0]        result_q,      result_d;
  logic                 done_q,        done_d;
  logic                 ovf_q,         ovf_d;

  logic signed [SW-1:0] sq_one_s, sq_two_s, half_one_s, half_two_s, sum_ext;
  logic                 acc_ovf;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic [DW-1:0]        cnt_res;

  // Magnitude of a two's complement value; the most negative value maps to
  // 2^(DW-1), which is still representable as an unsigned DW-bit number.
  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
    if (v[DW-1]) begin
      return ~v + DW'(1);
    end
    return v;
  endfunction

  // Clamp an accumulator value into the signed DATA_WIDTH result range.
  function automatic logic [DW-1:0] sat_data(input logic [ACC_WIDTH-1:0] v);
    if ((&v[ACC_WIDTH-1:DW-1]) || !(|v[ACC_WIDTH-1:DW-1])) begin
      return v[DW-1:0];
    end
    if (v[ACC_WIDTH-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end
    return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Squares are non-negative, so the logical shift equals the floor shift.
  assign sq_one_s   = $signed(SW'(prod_one_q >> FRAC_BITS));
  assign sq_two_s   = $signed(SW'(prod_two_q >> FRAC_BITS));
  assign half_one_s = $signed({{(SW-DW){xo_q[DW-1]}}, xo_q}) >>> 1;
  assign half_two_s = $signed({{(SW-DW){xt_q[DW-1]}}, xt_q}) >>> 1;
  assign sum_ext    = $signed({{2{sum_q[ACC_WIDTH-1]}}, sum_q})
                      + sq_one_s + half_one_s + sq_two_s + half_two_s;

  // Out of range whenever the bits above the accumulator sign disagree.
  assign acc_ovf = !((&sum_ext[SW-1:ACC_WIDTH-1]) || !(|sum_ext[SW-1:ACC_WIDTH-1]));
  assign acc_sat = !acc_ovf       ? sum_ext[ACC_WIDTH-1:0] :
                   sum_ext[SW-1]  ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                    {1'b0, {(ACC_WIDTH-1){1'b1}}};

  if (CNT_WIDTH >= DATA_WIDTH) begin : g_cnt_trunc
    assign cnt_res = count_q[DW-1:0];
  end else begin : g_cnt_ext
    assign cnt_res = {{(DW-CNT_WIDTH){1'b0}}, count_q};
  end

  // Next-state logic for the FSM, both multipliers and the accumulator.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    xo_d         = xo_q;
    xt_d         = xt_q;
    mcand_one_d  = mcand_one_q;
    mcand_two_d  = mcand_two_q;
    mplier_one_d = mplier_one_q;
    mplier_two_d = mplier_two_q;
    prod_one_d   = prod_one_q;
    prod_two_d   = prod_two_q;
    sum_d        = sum_q;
    count_d      = count_q;
    result_d     = result_q;
    done_d       = done_q;
    ovf_d        = ovf_q;

    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (start) begin
            case (n)
              OP_CLEAR: begin
                sum_d    = '0;
                count_d  = '0;
                ovf_d    = 1'b0;
                result_d = '0;
                done_d   = 1'b1;
                state_d  = S_DONE;
              end
              OP_GO: begin
                xo_d         = x_one;
                xt_d         = x_two;
                mcand_one_d  = {{DW{1'b0}}, magnitude(x_one)};
                mcand_two_d  = {{DW{1'b0}}, magnitude(x_two)};
                mplier_one_d = magnitude(x_one);
                mplier_two_d = magnitude(x_two);
                prod_one_d   = '0;
                prod_two_d   = '0;
                iter_d       = IW'(DATA_WIDTH);
                state_d      = S_MULT;
              end
              OP_READ: begin
                result_d = sat_data(sum_q);
                done_d   = 1'b1;
                state_d  = S_DONE;
              end
              default: begin
                result_d = cnt_res;
                done_d   = 1'b1;
                state_d  = S_DONE;
              end
            endcase
          end
        end
        S_MULT: begin
          if (mplier_one_q[0]) begin
            prod_one_d = prod_one_q + mcand_one_q;
          end
          if (mplier_two_q[0]) begin
            prod_two_d = prod_two_q + mcand_two_q;
          end
          mcand_one_d  = mcand_one_q << 1;
          mcand_two_d  = mcand_two_q << 1;
          mplier_one_d = mplier_one_q >> 1;
          mplier_two_d = mplier_two_q >> 1;
          iter_d       = iter_q - IW'(1);
          if (iter_q == IW'(1)) begin
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          sum_d    = acc_sat;
          ovf_d    = ovf_q | acc_ovf;
          if (!(&count_q)) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          result_d = sat_data(acc_sat);
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; the enable is folded into the next-state logic above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      iter_q       <= '0;
      xo_q         <= '0;
      xt_q         <= '0;
      mcand_one_q  <= '0;
      mcand_two_q  <= '0;
      mplier_one_q <= '0;
      mplier_two_q <= '0;
      prod_one_q   <= '0;
      prod_two_q   <= '0;
      sum_q        <= '0;
      count_q      <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      xo_q         <= xo_d;
      xt_q         <= xt_d;
      mcand_one_q  <= mcand_one_d;
      mcand_two_q  <= mcand_two_d;
      mplier_one_q <= mplier_one_d;
      mplier_two_q <= mplier_two_d;
      prod_one_q   <= prod_one_d;
      prod_two_q   <= prod_two_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      result_q     <= result_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
